// File: rtl/decoder_nx2n_seq_if.sv
// decoder_nx2n_seq_if: control and result bundle of the registered N-to-2^N decoder.
// The master side drives enable, mode and the select handshake; the slave side
// (the decoder) returns the handshake ready, the decoded word and scan status.
interface decoder_nx2n_seq_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel_in;
    logic             sel_valid;
    logic             sel_ready;
    logic [OUT_W-1:0] y_out;
    logic             scan_wrap;
    logic             busy;

    modport master (
        output en, mode, sel_in, sel_valid,
        input  sel_ready, y_out, scan_wrap, busy
    );

    modport slave (
        input  en, mode, sel_in, sel_valid,
        output sel_ready, y_out, scan_wrap, busy
    );
endinterface

// File: rtl/decoder_nx2n_seq.sv
// decoder_nx2n_seq: registered N-to-2^N one-hot decoder with a direct mode
// (handshaked select codes) and a scan mode (one-hot walk, HOLD_CYC cycles per
// position). y_out and scan_wrap come straight from flops; sel_ready and busy
// are decoded from the state register only.
// Optional build macro DEC_ACTIVE_LOW_OUT_EN: y_out becomes one-cold (all-ones
// when off) with identical timing.
module decoder_nx2n_seq #(
    parameter int SEL_W    = 2,
    parameter int HOLD_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_nx2n_seq_if.slave  bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int DW_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(HOLD_CYC - 1);
    localparam logic [SEL_W-1:0] POS_LAST   = {SEL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // One-hot word with bit p set.
    function automatic logic [OUT_W-1:0] hot(input logic [SEL_W-1:0] p);
        hot = OUT_W'(1) << p;
    endfunction

    // Apply the output polarity at the register input.
    function automatic logic [OUT_W-1:0] y_encode(input logic [OUT_W-1:0] v);
`ifdef DEC_ACTIVE_LOW_OUT_EN
        y_encode = ~v;
`else
        y_encode = v;
`endif
    endfunction

    localparam logic [OUT_W-1:0] Y_OFF = y_encode({OUT_W{1'b0}});

    state_t            state_q, state_d;
    logic [OUT_W-1:0]  y_q, y_d;
    logic              wrap_q, wrap_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [SEL_W-1:0]  pos_q, pos_d;
    logic [SEL_W-1:0]  pos_nxt_s;
    logic              sel_ready_s;
    logic              xfer_s;

    assign sel_ready_s   = (state_q == ST_DIRECT);
    assign xfer_s        = bus.sel_valid && sel_ready_s;
    assign pos_nxt_s     = pos_q + SEL_W'(1);

    assign bus.sel_ready = sel_ready_s;
    assign bus.busy      = (state_q == ST_SCAN);
    assign bus.y_out     = y_q;
    assign bus.scan_wrap = wrap_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; a low enable overrides everything.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = bus.mode ? ST_SCAN : ST_DIRECT;
                ST_DIRECT: state_d = bus.mode ? ST_SCAN : ST_DIRECT;
                ST_SCAN:   state_d = bus.mode ? ST_SCAN : ST_DIRECT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values: decode word, wrap pulse, dwell and position.
    always_comb begin
        y_d     = y_q;
        wrap_d  = 1'b0;
        dwell_d = dwell_q;
        pos_d   = pos_q;
        if (!bus.en) begin
            y_d     = Y_OFF;
            dwell_d = {DW_W{1'b0}};
            pos_d   = {SEL_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mode) begin
                        y_d     = y_encode(hot({SEL_W{1'b0}}));
                        dwell_d = {DW_W{1'b0}};
                        pos_d   = {SEL_W{1'b0}};
                    end else begin
                        y_d     = Y_OFF;
                    end
                end
                ST_DIRECT: begin
                    // A scan request wins over a same-cycle transfer.
                    if (bus.mode) begin
                        y_d     = y_encode(hot({SEL_W{1'b0}}));
                        dwell_d = {DW_W{1'b0}};
                        pos_d   = {SEL_W{1'b0}};
                    end else if (xfer_s) begin
                        y_d     = y_encode(hot(bus.sel_in));
                    end else begin
                        y_d     = y_q;
                    end
                end
                ST_SCAN: begin
                    if (!bus.mode) begin
                        // Leave scan: the last scan word stays on y_out.
                        dwell_d = {DW_W{1'b0}};
                        pos_d   = {SEL_W{1'b0}};
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = {DW_W{1'b0}};
                        pos_d   = pos_nxt_s;
                        y_d     = y_encode(hot(pos_nxt_s));
                        wrap_d  = (pos_q == POS_LAST);
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                default: begin
                    y_d     = Y_OFF;
                    dwell_d = {DW_W{1'b0}};
                    pos_d   = {SEL_W{1'b0}};
                end
            endcase
        end
    end

    // Datapath registers: output word, wrap pulse, dwell counter, scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= Y_OFF;
            wrap_q  <= 1'b0;
            dwell_q <= {DW_W{1'b0}};
            pos_q   <= {SEL_W{1'b0}};
        end else begin
            y_q     <= y_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
            pos_q   <= pos_d;
        end
    end
endmodule

// File: doc/decoder_nx2n_seq.md
Name: decoder_nx2n_seq

Overview:
Parametrised registered N-to-2^N one-hot decoder, successor to the team's combinational 2x4 decoder. Two modes: direct mode decodes handshaked select codes; scan mode walks a one-hot pattern across all outputs with a programmable dwell time. Used for row/bank/LED-digit select in later designs, where outputs must be glitch-free and registered.

Parameters:
SEL_W, 2, select width; output width OUT_W = 2**SEL_W (SEL_W 1..6)
HOLD_CYC, 4, scan dwell in clock cycles per output position (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset
en  input  1  block enable; low forces outputs off
mode  input  1  0 = direct decode, 1 = scan
sel_in  input  SEL_W  select code (direct mode)
sel_valid  input  1  sel_in valid
sel_ready  output  1  block accepts sel_in this cycle
y_out  output  OUT_W  registered one-hot decode
scan_wrap  output  1  one-cycle pulse when scan wraps to position 0
busy  output  1  high in SCAN state

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, y_out=0, sel_ready=0, scan_wrap=0, busy=0, dwell counter=0, scan position=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to y_out.
- FSM states: IDLE, DIRECT, SCAN.
- IDLE: y_out=0. If en&&!mode, go to DIRECT. If en&&mode, go to SCAN, and on that edge y_out<=1 (position 0), dwell=0.
- DIRECT: sel_ready=1. Handshake completes when sel_valid&&sel_ready. On that edge, y_out <= 1<<sel_in (latency 1 cycle). Without a transfer, y_out holds. If mode=1, go to SCAN, restarting at position 0 (y_out<=1, dwell=0); any same-cycle transfer is ignored.
- SCAN: sel_ready=0, busy=1.
  - dwell increments each cycle.
  - When dwell==HOLD_CYC-1: dwell<=0 and position<=position+1. Position wraps from OUT_W-1 to 0.
  - y_out tracks position, so each bit is high for exactly HOLD_CYC cycles.
  - scan_wrap=1 in the same cycle y_out returns to bit 0 after a wrap. It does not pulse on initial entry.
  - If mode=0, go to DIRECT; y_out holds its last scan value until the next transfer.
- en low has priority in every state. Next edge: state=IDLE, y_out=0, dwell=0, position=0, scan_wrap=0. sel_ready drops combinationally with state (it is already 0 in the en-low cycle only if the state is not DIRECT; the transfer in that cycle is discarded).
- HOLD_CYC=1: position advances every cycle.
- y_out is always all-zero or exactly one-hot.
- Async reset mid-scan or mid-handshake immediately returns all outputs to their reset values.

Optional Feature:
DEC_ACTIVE_LOW_OUT_EN
- Defined: y_out is inverted at the output register (one-cold, 74x139 style). Reset and IDLE drive all-ones. All other timing is identical.
- Undefined: active-high one-hot as described above.

Test Plan:
- Reset/idle: assert rst_n=0 mid-scan, then release with en=0 -> y_out=0000, sel_ready=0, busy=0, scan_wrap=0.
- Direct decode: en=1, mode=0, push sel_in=0,1,2,3 back-to-back with sel_valid=1 -> y_out=0001,0010,0100,1000, each one cycle after its transfer. sel_valid=0 -> y_out holds 1000.
- Scan, defaults: en=1, mode=1 -> y_out=0001 for 4 cycles, then 0010, 0100, 1000 for 4 each, then 0001 with scan_wrap=1 for exactly one cycle (cycle 17 after entry). sel_ready=0 throughout.
- Mode switch: in SCAN at y_out=0100, set mode=0 -> DIRECT, y_out holds 0100, sel_ready=1. Then mode=1 -> scan restarts at 0001.
- Enable priority: en=0 in the same cycle as sel_valid with sel_in=3 -> no transfer, y_out=0000 next cycle, state IDLE.
- Parametrisation: SEL_W=3, HOLD_CYC=1 -> scan covers bits 0..7, one per cycle, scan_wrap every 8 cycles. Repeat with DEC_ACTIVE_LOW_OUT_EN defined -> inverted patterns (e.g. 11111110) and reset value 11111111.
